mux_b_t_t_n: RTL and testbench
==============================

# mux_b_t_t_n

Multi-channel temporal-select / binary-data multiplexer for the race-logic datapath. Each of NUM_CHANNELS temporal `select` lines is timed within a gamma cycle by a shared wrapping counter, with first-event capture per channel. At each gamma-cycle end, every captured time is matched against a shared table of binary `inputs`, and per-channel result, hit flag and matching index are published with a one-cycle valid strobe. Successor to the single-channel rising-edge mux: explicit capture flags (time 0 is capturable), selectable edge/level mode, match index reporting, registered gamma-framed outputs.

## Interface
- GAMMA_CYCLE_WIDTH, 16, clock cycles per gamma cycle (≥2, need not be a power of 2)
- NUM_CHANNELS, 4, number of independent temporal select channels
- NUM_INPUTS, GAMMA_CYCLE_WIDTH, binary table entries
- INPUT_WIDTH, $clog2(GAMMA_CYCLE_WIDTH), bits per table entry / time value
- IDX_WIDTH, max(1,$clog2(NUM_INPUTS)), bits of match index
- EDGE_MODE, 0, 0 = capture on 0→1 transition of select; 1 = capture on first cycle select is high
- aclk  in  1  clock
- grst  in  1  reset; asynchronous, active-high
- inputs  in  [NUM_INPUTS-1:0][INPUT_WIDTH-1:0]  binary table, shared by all channels
- select  in  [NUM_CHANNELS-1:0]  temporal select, one per channel
- out  out  [NUM_CHANNELS-1:0][INPUT_WIDTH-1:0]  matched time per channel
- hit  out  [NUM_CHANNELS-1:0]  captured time matched a table entry
- fired  out  [NUM_CHANNELS-1:0]  channel captured an event in the reported gamma cycle
- match_idx  out  [NUM_CHANNELS-1:0][IDX_WIDTH-1:0]  lowest table index equal to captured time
- out_valid  out  1  one-cycle strobe, new results on out/hit/fired/match_idx
- gamma_count  out  INPUT_WIDTH  current position in gamma cycle
- gamma_start  out  1  high while gamma_count == 0

## Operation
- Counter: reset 0; +1 per aclk; GAMMA_CYCLE_WIDTH-1 wraps to 0. Cycle with count 0 is the first of a gamma cycle, count G-1 is the last.
- Per channel: `captured` flag (reset 0), `cap_time` register (reset 0), `select_d` delayed select (reset 0, never cleared at gamma boundary).
- Capture condition: EDGE_MODE=0: select & ~select_d; EDGE_MODE=1: select. If condition true and captured=0 in cycle with count t: captured←1, cap_time←t. Later events in the same gamma cycle are ignored.
- Evaluation in last cycle (count G-1), using next-state capture values (so an event at t=G-1 counts):
  - fired = captured_next
  - hit = fired and some inputs[i] == cap_time_next
  - match_idx = lowest such i when hit, else 0
  - out = cap_time_next when hit, else 0
  - Registered at the G-1→0 edge; captured flags cleared on the same edge.
- inputs is sampled only in the last cycle; changes at other times have no effect.
- Entries with value ≥ GAMMA_CYCLE_WIDTH never match.
- Channels are fully independent; simultaneous events on all channels in one cycle are all captured.

## Timing
- Reset (async assert): counter 0, all captured/cap_time/select_d 0, out/hit/fired/match_idx 0, out_valid 0, gamma_start 1.
- Reset mid-gamma-cycle: any pending capture discarded; no out_valid for the aborted cycle. After release, count 0 in first clocked cycle. First out_valid arrives G cycles later.
- Latency: event at count t of gamma cycle k → results visible at count 0 of cycle k+1, i.e. G−t cycles after capture edge.
- out_valid: high exactly in cycle with count 0 following a completed gamma cycle; never on the first count-0 after reset.
- Outputs hold between strobes.
- EDGE_MODE=0 with select held high across a boundary: no capture in the new cycle until select falls and rises again.

## Test plan
- Ch0 rises at t=5, inputs[3]=5, others ≠5 → at next count 0: out[0]=5, hit[0]=1, fired[0]=1, match_idx[0]=3, out_valid high 1 cycle; other channels fired=0, out=0. Repeat with rise at t=15 → out[0]=15, reported same way.
- Ch1 rises at t=0, inputs[0]=0, second pulse at t=7 → out[1]=0, hit[1]=1, fired[1]=1, match_idx[1]=0 (time 0 captured; t=7 ignored).
- Ch2 rises at t=9, no entry equals 9 → fired[2]=1, hit[2]=0, out[2]=0, match_idx[2]=0.
- inputs[2]=inputs[6]=4, all channels rise at t=4 → every channel hit=1, out=4, match_idx=2.
- Select held high from t=10 through next gamma cycle: EDGE_MODE=0 → second report fired=0; EDGE_MODE=1 → second report fired=1, out=0 if inputs has 0.
- Capture at t=3, grst pulsed at t=8 → all outputs 0 immediately, no out_valid until G cycles after release, that report shows fired=0.

Source files
------------

// File: rtl/mux_b_t_t_n.sv
// Multi-channel race-logic mux. Each temporal select channel records the time of
// its first event in a gamma cycle; those times are matched against a shared table.
module mux_b_t_t_n #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int NUM_CHANNELS      = 4,
  parameter int NUM_INPUTS        = GAMMA_CYCLE_WIDTH,
  parameter int INPUT_WIDTH       = $clog2(GAMMA_CYCLE_WIDTH),
  parameter int IDX_WIDTH         = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  parameter bit EDGE_MODE         = 1'b0
) (
  input  logic                                     aclk,
  input  logic                                     grst,
  input  logic [NUM_INPUTS-1:0][INPUT_WIDTH-1:0]   inputs,
  input  logic [NUM_CHANNELS-1:0]                  select,
  output logic [NUM_CHANNELS-1:0][INPUT_WIDTH-1:0] out,
  output logic [NUM_CHANNELS-1:0]                  hit,
  output logic [NUM_CHANNELS-1:0]                  fired,
  output logic [NUM_CHANNELS-1:0][IDX_WIDTH-1:0]   match_idx,
  output logic                                     out_valid,
  output logic [INPUT_WIDTH-1:0]                   gamma_count,
  output logic                                     gamma_start
);

  localparam logic [INPUT_WIDTH-1:0] LAST_COUNT = INPUT_WIDTH'(GAMMA_CYCLE_WIDTH - 1);

  logic                                     last_cycle;
  logic [NUM_CHANNELS-1:0]                  captured;
  logic [NUM_CHANNELS-1:0][INPUT_WIDTH-1:0] cap_time;
  logic [NUM_CHANNELS-1:0]                  select_d;
  logic [NUM_CHANNELS-1:0]                  capture_event;
  logic [NUM_CHANNELS-1:0]                  captured_next;
  logic [NUM_CHANNELS-1:0][INPUT_WIDTH-1:0] cap_time_next;
  logic [NUM_INPUTS-1:0]                    entry_in_range;
  logic [NUM_CHANNELS-1:0]                  eval_hit;
  logic [NUM_CHANNELS-1:0][IDX_WIDTH-1:0]   eval_idx;
  logic [NUM_CHANNELS-1:0][INPUT_WIDTH-1:0] eval_out;

  assign last_cycle  = (gamma_count == LAST_COUNT);
  assign gamma_start = (gamma_count == '0);

  // Wrapping gamma counter; the modulus need not be a power of two.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      gamma_count <= '0;
    end else if (last_cycle) begin
      gamma_count <= '0;
    end else begin
      gamma_count <= gamma_count + 1'b1;
    end
  end

  always_comb begin
    capture_event = '0;
    captured_next = '0;
    cap_time_next = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      capture_event[c] = EDGE_MODE ? select[c] : (select[c] & ~select_d[c]);
      captured_next[c] = captured[c] | capture_event[c];
      cap_time_next[c] = (capture_event[c] && !captured[c]) ? gamma_count : cap_time[c];
    end
  end

  // select_d deliberately survives the gamma boundary so a held-high line cannot re-trigger.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      captured <= '0;
      cap_time <= '0;
      select_d <= '0;
    end else begin
      captured <= last_cycle ? '0 : captured_next;
      cap_time <= cap_time_next;
      select_d <= select;
    end
  end

  always_comb begin
    entry_in_range = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      entry_in_range[i] = (int'(inputs[i]) < GAMMA_CYCLE_WIDTH);
    end
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    eval_hit = '0;
    eval_idx = '0;
    eval_out = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
        if (captured_next[c] && entry_in_range[i] && (inputs[i] == cap_time_next[c])) begin
          eval_hit[c] = 1'b1;
          eval_idx[c] = IDX_WIDTH'(i);
        end
      end
      if (eval_hit[c]) begin
        eval_out[c] = cap_time_next[c];
      end
    end
  end

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      out       <= '0;
      hit       <= '0;
      fired     <= '0;
      match_idx <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= last_cycle;
      if (last_cycle) begin
        out       <= eval_out;
        hit       <= eval_hit;
        fired     <= captured_next;
        match_idx <= eval_idx;
      end
    end
  end

endmodule

// File: tb/tb_mux_b_t_t_n.sv
// Directed bench for mux_b_t_t_n: edge-mode and level-mode instances share stimulus
// and are compared every cycle against a first-event-per-gamma-cycle model.
module tb_mux_b_t_t_n;

  localparam int G  = 16;
  localparam int NC = 4;
  localparam int NI = 16;
  localparam int IW = 4;
  localparam int XW = 4;

  logic                    aclk;
  logic                    grst;
  logic [NI-1:0][IW-1:0]   tbl;
  logic [NC-1:0]           select_tb;

  logic [NC-1:0][IW-1:0]   d_out   [2];
  logic [NC-1:0]           d_hit   [2];
  logic [NC-1:0]           d_fired [2];
  logic [NC-1:0][XW-1:0]   d_idx   [2];
  logic                    d_valid [2];
  logic [IW-1:0]           d_cnt   [2];
  logic                    d_start [2];

  int n_vec = 0;
  int n_bad = 0;

  // Model state: time of first event per channel this gamma cycle, -1 when none.
  int m_cnt;
  int m_first [2][NC];
  bit m_prev  [2][NC];
  int e_out   [2][NC];
  int e_hit   [2][NC];
  int e_fired [2][NC];
  int e_idx   [2][NC];
  int e_valid [2];

  mux_b_t_t_n #(.EDGE_MODE(1'b0)) dut_edge (
    .aclk(aclk), .grst(grst), .inputs(tbl), .select(select_tb),
    .out(d_out[0]), .hit(d_hit[0]), .fired(d_fired[0]), .match_idx(d_idx[0]),
    .out_valid(d_valid[0]), .gamma_count(d_cnt[0]), .gamma_start(d_start[0])
  );

  mux_b_t_t_n #(.EDGE_MODE(1'b1)) dut_level (
    .aclk(aclk), .grst(grst), .inputs(tbl), .select(select_tb),
    .out(d_out[1]), .hit(d_hit[1]), .fired(d_fired[1]), .match_idx(d_idx[1]),
    .out_valid(d_valid[1]), .gamma_count(d_cnt[1]), .gamma_start(d_start[1])
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic resetModel();
    m_cnt = 0;
    for (int m = 0; m < 2; m++) begin
      e_valid[m] = 0;
      for (int c = 0; c < NC; c++) begin
        m_first[m][c] = -1;
        m_prev[m][c]  = 1'b0;
        e_out[m][c]   = 0;
        e_hit[m][c]   = 0;
        e_fired[m][c] = 0;
        e_idx[m][c]   = 0;
      end
    end
  endtask

  initial begin
    resetModel();
    forever begin
      @(posedge aclk or posedge grst);
      if (grst) begin
        resetModel();
      end else begin
        for (int m = 0; m < 2; m++) begin
          for (int c = 0; c < NC; c++) begin
            bit ev;
            ev = (m == 1) ? select_tb[c] : (select_tb[c] && !m_prev[m][c]);
            if (ev && m_first[m][c] < 0) m_first[m][c] = m_cnt;
            m_prev[m][c] = select_tb[c];
          end
          if (m_cnt == G - 1) begin
            e_valid[m] = 1;
            for (int c = 0; c < NC; c++) begin
              e_fired[m][c] = (m_first[m][c] >= 0) ? 1 : 0;
              e_hit[m][c] = 0;
              e_out[m][c] = 0;
              e_idx[m][c] = 0;
              if (m_first[m][c] >= 0) begin
                for (int i = 0; i < NI; i++) begin
                  if (e_hit[m][c] == 0 && int'(tbl[i]) < G && int'(tbl[i]) == m_first[m][c]) begin
                    e_hit[m][c] = 1;
                    e_idx[m][c] = i;
                    e_out[m][c] = m_first[m][c];
                  end
                end
              end
              m_first[m][c] = -1;
            end
          end else begin
            e_valid[m] = 0;
          end
        end
        m_cnt = (m_cnt + 1) % G;
      end
    end
  end

  initial begin
    forever begin
      @(negedge aclk);
      for (int m = 0; m < 2; m++) begin
        checkOutput($sformatf("i%0d.gamma_count", m), int'(d_cnt[m]), m_cnt);
        checkOutput($sformatf("i%0d.gamma_start", m), int'(d_start[m]), (m_cnt == 0) ? 1 : 0);
        checkOutput($sformatf("i%0d.out_valid", m), int'(d_valid[m]), e_valid[m]);
        for (int c = 0; c < NC; c++) begin
          checkOutput($sformatf("i%0d.out[%0d]", m, c), int'(d_out[m][c]), e_out[m][c]);
          checkOutput($sformatf("i%0d.hit[%0d]", m, c), int'(d_hit[m][c]), e_hit[m][c]);
          checkOutput($sformatf("i%0d.fired[%0d]", m, c), int'(d_fired[m][c]), e_fired[m][c]);
          checkOutput($sformatf("i%0d.match_idx[%0d]", m, c), int'(d_idx[m][c]), e_idx[m][c]);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [NC-1:0] s);
    select_tb = s;
  endtask

  task automatic waitCount(input int t);
    int n = 0;
    do begin
      @(posedge aclk);
      #1;
      n++;
    end while (m_cnt != t && n < 2 * G);
    if (m_cnt != t) checkOutput("waitCount timeout", m_cnt, t);
  endtask

  task automatic loadTable();
    for (int i = 0; i < NI; i++) tbl[i] = IW'(i);
    tbl[3] = 4'd5;
    tbl[5] = 4'd3;
  endtask

  initial begin
    grst = 1'b1;
    applyStimulus('0);
    loadTable();
    repeat (2) @(posedge aclk);
    #1;
    checkOutput("reset gamma_count", int'(d_cnt[0]), 0);
    checkOutput("reset gamma_start", int'(d_start[0]), 1);
    checkOutput("reset out_valid", int'(d_valid[0]), 0);
    checkOutput("reset fired", int'(d_fired[0]), 0);
    grst = 1'b0;

    // Ch0 at t=5 matches table index 3
    waitCount(5);  applyStimulus(4'b0001);
    waitCount(6);  applyStimulus(4'b0000);
    waitCount(0);
    checkOutput("t5 out[0]", int'(d_out[0][0]), 5);
    checkOutput("t5 hit[0]", int'(d_hit[0][0]), 1);
    checkOutput("t5 fired[0]", int'(d_fired[0][0]), 1);
    checkOutput("t5 match_idx[0]", int'(d_idx[0][0]), 3);
    checkOutput("t5 out_valid", int'(d_valid[0]), 1);
    checkOutput("t5 fired[1]", int'(d_fired[0][1]), 0);
    checkOutput("t5 out[1]", int'(d_out[0][1]), 0);
    waitCount(1);
    checkOutput("t5 strobe drop", int'(d_valid[0]), 0);
    checkOutput("t5 out hold", int'(d_out[0][0]), 5);

    // Event in the very last cycle still counts
    waitCount(15); applyStimulus(4'b0001);
    waitCount(0);  applyStimulus(4'b0000);
    checkOutput("t15 out[0]", int'(d_out[0][0]), 15);
    checkOutput("t15 match_idx[0]", int'(d_idx[0][0]), 15);
    checkOutput("t15 hit[0]", int'(d_hit[0][0]), 1);

    // Ch1 at t=0, second pulse at t=7 ignored
    applyStimulus(4'b0010);
    waitCount(1);  applyStimulus(4'b0000);
    waitCount(7);  applyStimulus(4'b0010);
    waitCount(8);  applyStimulus(4'b0000);
    waitCount(0);
    checkOutput("t0 out[1]", int'(d_out[0][1]), 0);
    checkOutput("t0 hit[1]", int'(d_hit[0][1]), 1);
    checkOutput("t0 fired[1]", int'(d_fired[0][1]), 1);
    checkOutput("t0 match_idx[1]", int'(d_idx[0][1]), 0);
    checkOutput("t0 fired[0]", int'(d_fired[0][0]), 0);

    // Ch2 at t=9; table briefly holds 9 mid-cycle but not in the last cycle
    waitCount(3);  tbl[9] = 4'd9;
    waitCount(9);  applyStimulus(4'b0100);
    waitCount(10); applyStimulus(4'b0000);
    waitCount(12); tbl[9] = 4'd10;
    waitCount(0);
    checkOutput("miss fired[2]", int'(d_fired[0][2]), 1);
    checkOutput("miss hit[2]", int'(d_hit[0][2]), 0);
    checkOutput("miss out[2]", int'(d_out[0][2]), 0);
    checkOutput("miss match_idx[2]", int'(d_idx[0][2]), 0);
    loadTable();

    // All channels at t=4; duplicates at 2 and 6 resolve to the lower index
    tbl[2] = 4'd4; tbl[6] = 4'd4; tbl[4] = 4'd2;
    waitCount(4);  applyStimulus(4'b1111);
    waitCount(5);  applyStimulus(4'b0000);
    waitCount(0);
    for (int c = 0; c < NC; c++) begin
      checkOutput($sformatf("dup hit[%0d]", c), int'(d_hit[0][c]), 1);
      checkOutput($sformatf("dup out[%0d]", c), int'(d_out[0][c]), 4);
      checkOutput($sformatf("dup match_idx[%0d]", c), int'(d_idx[0][c]), 2);
    end
    loadTable();

    // Ch3 held high from t=10 across a whole gamma cycle
    waitCount(10); applyStimulus(4'b1000);
    waitCount(0);
    checkOutput("hold1 out[3]", int'(d_out[0][3]), 10);
    checkOutput("hold1 level out[3]", int'(d_out[1][3]), 10);
    waitCount(0);
    checkOutput("hold2 edge fired[3]", int'(d_fired[0][3]), 0);
    checkOutput("hold2 level fired[3]", int'(d_fired[1][3]), 1);
    checkOutput("hold2 level hit[3]", int'(d_hit[1][3]), 1);
    checkOutput("hold2 level out[3]", int'(d_out[1][3]), 0);
    applyStimulus(4'b0000);

    // Capture at t=3, reset at t=8 discards it
    waitCount(3);  applyStimulus(4'b0001);
    waitCount(4);  applyStimulus(4'b0000);
    waitCount(8);
    grst = 1'b1;
    #2;
    checkOutput("async hit level", int'(d_hit[1]), 0);
    checkOutput("async fired level", int'(d_fired[1]), 0);
    checkOutput("async out_valid", int'(d_valid[0]), 0);
    checkOutput("async gamma_count", int'(d_cnt[0]), 0);
    checkOutput("async gamma_start", int'(d_start[0]), 1);
    @(posedge aclk);
    #1;
    grst = 1'b0;
    checkOutput("release gamma_count", int'(d_cnt[0]), 0);
    for (int k = 1; k <= G; k++) begin
      @(posedge aclk);
      #1;
      checkOutput($sformatf("post-reset out_valid k=%0d", k), int'(d_valid[0]), (k == G) ? 1 : 0);
      if (k == G) begin
        checkOutput("post-reset fired edge", int'(d_fired[0]), 0);
        checkOutput("post-reset fired level", int'(d_fired[1]), 0);
      end
    end

    repeat (2) @(posedge aclk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
